fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of an async_fifo among NUM_REQ requesters in the write-clock domain.
- Each requester uses a valid/ready handshake. The granted requester keeps the FIFO write port for a burst of up to MAX_BURST beats, then the grant rotates.
- The block drives async_fifo wr_en/wr_din and honours fifo_full. No data is lost or duplicated at the FIFO boundary.

Parameters:
- NUM_REQ, 4: number of requesters, ≥1.
- DATA_WIDTH, 8: data width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4: maximum beats accepted per grant, ≥1.
- ID_W, $clog2(NUM_REQ) (minimum 1): width of gnt_id.

Ports:
- clk  in  1  single clock (FIFO write clock, clk_wr domain).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester ready (beat accepted when valid&ready).
- fifo_full  in  1  from async_fifo.
- wr_en  out  1  to async_fifo.
- wr_din  out  DATA_WIDTH  to async_fifo.
- gnt_id  out  ID_W  index of the current/last grantee.
- busy  out  1  high while in GRANT.

Behaviour:
- Clock/reset: one clock (clk). Asynchronous active-low reset (rst_n).
- Reset values:
  - state=IDLE, ptr=0, gnt_id=0, burst_cnt=0.
  - busy=0, wr_en=0, wr_din=0, req_ready=0.
- FSM states: IDLE, GRANT.
- IDLE:
  - No beats are accepted. req_ready=0, wr_en=0, wr_din=0.
  - If any req_valid is high, select the first valid index searching upward from ptr with wrap-around (ptr, ptr+1, …, NUM_REQ-1, 0, …).
  - Register that index into gnt_id, clear burst_cnt, and go to GRANT next cycle.
- GRANT (g = gnt_id):
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - wr_en = req_valid[g] & !fifo_full (combinational; no registered lag on fifo_full).
  - wr_din = req_data[g] (combinational mux).
  - Beat: a cycle with wr_en=1. On a beat, burst_cnt increments.
  - Release to IDLE on the next edge, with ptr <= g+1 (mod NUM_REQ), when either:
    - a beat occurs with burst_cnt==MAX_BURST-1, or
    - req_valid[g]==0 (no beat in that cycle).
  - fifo_full=1 with req_valid[g]=1: hold the grant, freeze burst_cnt, wr_en=0. No timeout.
- Latency and throughput:
  - A request seen in IDLE at cycle N gets its first beat at cycle N+1 at the earliest.
  - Each grant costs one IDLE bubble cycle. MAX_BURST=1 therefore limits throughput to 50%.
- Fairness: a requester that remains valid is granted within (NUM_REQ-1) other grants.
- NUM_REQ=1: ptr is always 0 and the FSM is unchanged.
- Simultaneous events:
  - A final beat and fifo_full rising on the same edge: the beat counts.
  - fifo_full is sampled only combinationally in the beat cycle.
- Mid-operation reset: asynchronous return to reset values. A beat in progress at the reset edge is not written (wr_en forced 0).
- Requester rule: data must be stable while valid & !ready. Dropping valid ends the grant.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds output beat_cnt (NUM_REQ*16): per-requester 16-bit counter of accepted beats, packed like req_data.
  - Counters saturate at 16'hFFFF and are cleared by rst_n.
  - Also adds output stall_cnt (16): cycles spent in GRANT with req_valid[g]=1 and fifo_full=1, saturating.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Single requester 0, 6 valid beats (data 0x10..0x15), MAX_BURST=4, fifo_full=0:
  - Expect the FIFO to receive 0x10..0x15 in order.
  - Expect a 1-cycle bubble after the 4th beat.
  - Expect gnt_id=0 on both grants.
- All 4 requesters continuously valid, each with distinct data:
  - Expect grant order 0,1,2,3,0, with 4 beats each.
  - Expect busy low for exactly 1 cycle between grants.
  - Expect no req_ready asserted outside the grantee.
- Requester 2 granted, fifo_full forced high for 5 cycles after its 2nd beat:
  - Expect wr_en=0 and req_ready[2]=0 for those 5 cycles, with burst_cnt frozen.
  - After release, expect beats 3–4 then rotation to 3.
- Requester 1 drops valid after 2 beats while requesters 1 and 3 are pending:
  - Expect release next edge and IDLE for 1 cycle.
  - Expect next grant=3, with ptr skipping 2 (not valid).
- Assert rst_n low mid-burst (after beat 2 of requester 0):
  - Expect wr_en=0, busy=0, gnt_id=0, req_ready=0 immediately (asynchronously).
  - After release, expect arbitration to restart from ptr=0.
- End-to-end with real async_fifo (DEPTH=16, rd clock 12 ns):
  - 4 requesters × 20 beats, with the reader draining at random.
  - Expect all 80 words read, per-requester order preserved, fifo_full never violated.
  - With FIFO_WR_ARB_STATS_EN defined, expect each beat_cnt=20.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of an async_fifo among
// NUM_REQ requesters in the FIFO write-clock domain. A granted requester keeps
// the port for up to MAX_BURST beats; the grant then rotates, with one IDLE
// cycle between grants.
//
// Handshake: a requester beat is accepted on a rising clk edge when
// req_valid[i] & req_ready[i] are both high. Only the grantee ever sees
// req_ready high, and only while fifo_full is low, so every accepted beat is
// exactly one wr_en cycle at the FIFO.
//
// Ports:
//   clk, rst_n  - write clock, asynchronous active-low reset
//   req_valid   - per-requester valid           [NUM_REQ]
//   req_data    - packed requester data, i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   - per-requester ready           [NUM_REQ]
//   fifo_full   - full flag from the FIFO
//   wr_en       - FIFO write enable
//   wr_din      - FIFO write data               [DATA_WIDTH]
//   gnt_id      - index of the current/last grantee [ID_W]
//   busy        - high while a grant is held
//   beat_cnt    - (FIFO_WR_ARB_STATS_EN) per-requester 16-bit accepted beats
//   stall_cnt   - (FIFO_WR_ARB_STATS_EN) GRANT cycles stalled by fifo_full
//   dbg_state   - FSM state (0 = IDLE, 1 = GRANT)
//
// Optional feature macro: FIFO_WR_ARB_STATS_EN (adds the saturating counters).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_din,
  output logic [ID_W-1:0]               gnt_id,
  output logic                          busy,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         beat_cnt,
  output logic [15:0]                   stall_cnt,
`endif
  output logic                          dbg_state
);

  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t                r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_gnt_id;
  logic [BC_W-1:0]       r_burst_cnt;

  logic                  w_grant;
  logic                  w_g_valid;
  logic [DATA_WIDTH-1:0] w_g_data;
  logic                  w_beat;
  logic                  w_last_beat;
  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_hi_found;
  logic [ID_W-1:0]       w_hi_sel;
  logic [ID_W-1:0]       w_lo_sel;
  logic [ID_W-1:0]       w_sel;
  logic [ID_W-1:0]       w_next_ptr;

  assign w_grant = (r_state == S_GRANT);

  // Grantee's valid and data, selected by the registered grant index.
  always_comb begin
    w_g_valid = 1'b0;
    w_g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt_id == ID_W'(i)) begin
        w_g_valid = req_valid[i];
        w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // fifo_full is used combinationally so a beat never lands on a full FIFO.
  assign w_beat      = w_grant & w_g_valid & ~fifo_full;
  assign w_last_beat = (r_burst_cnt == BC_W'(MAX_BURST - 1));

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_grant & ~fifo_full & (r_gnt_id == ID_W'(i));
    end
  end

  // Round-robin pick: lowest valid index at or above ptr; if none, wrap to the
  // lowest valid index overall. Loops run downward so the last hit is lowest.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (ID_W'(i) >= r_ptr)) begin
        w_hi_found = 1'b1;
        w_hi_sel   = ID_W'(i);
      end
      if (req_valid[i]) begin
        w_lo_sel = ID_W'(i);
      end
    end
    w_sel = w_hi_found ? w_hi_sel : w_lo_sel;
  end

  assign w_next_ptr = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt_id    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_gnt_id    <= w_sel;
            r_burst_cnt <= '0;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_beat) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_ptr   <= w_next_ptr;
            end else begin
              r_burst_cnt <= r_burst_cnt + BC_W'(1);
            end
          end else if (!w_g_valid) begin
            // Requester gave up the grant; stalls on fifo_full hold it instead.
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
          end
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign wr_en     = w_beat;
  assign wr_din    = w_grant ? w_g_data : '0;
  assign gnt_id    = r_gnt_id;
  assign busy      = w_grant;
  assign dbg_state = r_state;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] r_beat_cnt [NUM_REQ];
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_beat_cnt[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_beat && (r_gnt_id == ID_W'(i)) && (r_beat_cnt[i] != 16'hFFFF)) begin
          r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
        end
      end
      if (w_grant && w_g_valid && fifo_full && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_cnt[i*16 +: 16] = r_beat_cnt[i];
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requester drivers push every word they issue into
// a per-requester expected queue; a negedge monitor runs a grant-level model
// (round robin over valid requesters, MAX_BURST beats per grant, one idle cycle
// between grants) and compares the DUT outputs and written data against it.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    req_ready;
  logic            wr_en;
  logic [DW-1:0]   wr_din;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            dbg_state;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] beat_cnt;
  logic [15:0]     stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .wr_en(wr_en), .wr_din(wr_din),
    .gnt_id(gnt_id), .busy(busy),
`ifdef FIFO_WR_ARB_STATS_EN
    .beat_cnt(beat_cnt), .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [DW-1:0] exp_q [N][$];
  int n_checks = 0;
  int n_fail   = 0;

  int m_owner = -1;   // current grantee in the model, -1 when idle
  int m_beats = 0;    // beats taken in the current grant
  int m_ptr   = 0;    // first index searched at the next grant
  int m_last  = 0;    // last grantee
  int tb_beats [N];
  int tb_stall = 0;
  logic [N-1:0] acc = '0;  // beats accepted at the coming edge
  bit mon_en = 1'b0;

  // driver knobs and state
  int words_left [N];
  int seq [N];
  int base [N];
  bit pend [N];
  int p_valid = 100;
  int p_drop  = 0;
  int p_read  = 100;
  int fifo_cnt = 0;
  int words_read = 0;
  int force_full = 0;
  logic [N-1:0] force_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_next(input logic [N-1:0] v);
    logic [31:0] vv;
    int idx;
    vv = 32'(v);
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (vv[idx[4:0]]) return idx;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  logic [31:0] mon_v;
  logic [31:0] exp_rdy;
  int mg;
  bit mbeat;

  always @(negedge clk) begin
    if (mon_en) begin
      acc   = '0;
      mon_v = 32'(req_valid);
      if (m_owner < 0) begin
        check("idle_busy",   32'(busy),      32'd0);
        check("idle_wr_en",  32'(wr_en),     32'd0);
        check("idle_ready",  32'(req_ready), 32'd0);
        check("idle_wr_din", 32'(wr_din),    32'd0);
        check("idle_gnt_id", 32'(gnt_id),    32'(m_last));
        if (req_valid != '0) begin
          m_owner = pick_next(req_valid);
          m_beats = 0;
          m_last  = m_owner;
        end
      end else begin
        mg      = m_owner;
        mbeat   = mon_v[mg[4:0]] && !fifo_full;
        exp_rdy = fifo_full ? 32'd0 : (32'd1 << mg);
        check("grant_busy",   32'(busy),      32'd1);
        check("grant_gnt_id", 32'(gnt_id),    32'(mg));
        check("grant_wr_en",  32'(wr_en),     32'(mbeat));
        check("grant_ready",  32'(req_ready), exp_rdy);
        if (mbeat) begin
          if (exp_q[mg[1:0]].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_din: beat from requester %0d with no word outstanding", mg);
          end else begin
            check("wr_din", 32'(wr_din), 32'(exp_q[mg[1:0]].pop_front()));
          end
          acc[mg[1:0]] = 1'b1;
          tb_beats[mg]++;
          m_beats++;
          if (m_beats == MB) begin
            m_ptr   = (mg + 1) % N;
            m_owner = -1;
          end
        end else if (!mon_v[mg[4:0]]) begin
          m_ptr   = (mg + 1) % N;
          m_owner = -1;
        end else begin
          tb_stall++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle();
    bit dropped;
    logic [DW-1:0] d;
    if (acc != '0) fifo_cnt++;
    if (fifo_cnt > 0 && $urandom_range(0, 99) < p_read) begin
      fifo_cnt--;
      words_read++;
    end
    for (int i = 0; i < N; i++) begin
      dropped = 1'b0;
      if (req_valid[i] && acc[i]) begin
        req_valid[i] = 1'b0;
        pend[i] = 1'b0;
      end else if (req_valid[i] && $urandom_range(0, 99) < p_drop) begin
        req_valid[i] = 1'b0;
        dropped = 1'b1;
      end
      if (!req_valid[i] && !dropped) begin
        if (!pend[i] && words_left[i] > 0) begin
          d = DW'(base[i] + seq[i]);
          seq[i]++;
          words_left[i]--;
          pend[i] = 1'b1;
          req_data[i*DW +: DW] = d;
          exp_q[i].push_back(d);
        end
        if (pend[i] && $urandom_range(0, 99) < p_valid) req_valid[i] = 1'b1;
      end
      if (force_drop[i]) req_valid[i] = 1'b0;
    end
    force_drop = '0;
    fifo_full = (force_full > 0) || (fifo_cnt >= DEPTH);
    if (force_full > 0) force_full--;
  endtask

  function automatic bit all_done();
    bit d;
    d = (m_owner < 0) && (req_valid == '0);
    for (int i = 0; i < N; i++) begin
      if (words_left[i] != 0 || pend[i] || exp_q[i].size() != 0) d = 1'b0;
    end
    return d;
  endfunction

  task automatic setup(input int w0, input int w1, input int w2, input int w3,
                       input int pv, input int pd, input int pr);
    words_left[0] = w0; words_left[1] = w1; words_left[2] = w2; words_left[3] = w3;
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      base[i] = i * 64;
    end
    p_valid = pv; p_drop = pd; p_read = pr;
  endtask

  task automatic run_phase(input string name, input int maxc);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < maxc) begin
      @(posedge clk); #1;
      drive_cycle();
      c++;
      done = all_done();
    end
    check({name, "_complete"}, 32'(done), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      drive_cycle();
    end
  endtask

  // Drive until the model holds grant g with b beats taken; returns at
  // posedge+1 without driving that cycle.
  task automatic wait_grant(input string name, input int g, input int b, input int maxc);
    int c;
    bit found;
    c = 0;
    found = 1'b0;
    while (!found && c < maxc) begin
      @(posedge clk); #1;
      if (m_owner == g && m_beats == b) found = 1'b1;
      else drive_cycle();
      c++;
    end
    check({name, "_reached"}, 32'(found), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      tb_beats[i] = 0; pend[i] = 1'b0; words_left[i] = 0; seq[i] = 0; base[i] = 0;
    end
    #12;
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_wr_en",  32'(wr_en),     32'd0);
    check("rst_wr_din", 32'(wr_din),    32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_gnt_id", 32'(gnt_id),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Single requester 0: 0x10..0x15, two grants split by one idle cycle.
    setup(6, 0, 0, 0, 100, 0, 100);
    base[0] = 'h10;
    run_phase("single_req0", 100);

    // All requesters continuously valid: strict rotation, 4 beats each.
    setup(8, 8, 8, 8, 100, 0, 100);
    run_phase("all_valid", 200);

    // Requester 1 drops valid after 2 beats while 3 waits: next grant is 3.
    setup(0, 4, 0, 4, 100, 0, 100);
    wait_grant("drop_r1", 1, 2, 50);
    force_drop[1] = 1'b1;
    drive_cycle();
    run_phase("drop_r1", 200);

    // Requester 2 stalled by fifo_full for 5 cycles after its 2nd beat.
    setup(0, 0, 4, 4, 100, 0, 100);
    wait_grant("full_r2", 2, 2, 50);
    force_full = 5;
    drive_cycle();
    run_phase("full_r2", 200);

    // Random traffic with a slow reader and random valid drops.
    setup(12, 12, 12, 12, 70, 10, 30);
    run_phase("random", 3000);

    // Asynchronous reset in the middle of requester 1's burst.
    setup(8, 8, 8, 8, 100, 0, 100);
    wait_grant("midrst", 1, 2, 100);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en",  32'(wr_en),     32'd0);
    check("midrst_busy",   32'(busy),      32'd0);
    check("midrst_gnt_id", 32'(gnt_id),    32'd0);
    check("midrst_ready",  32'(req_ready), 32'd0);
    check("midrst_wr_din", 32'(wr_din),    32'd0);
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      pend[i] = 1'b0; words_left[i] = 0; tb_beats[i] = 0;
    end
    m_owner = -1; m_beats = 0; m_ptr = 0; m_last = 0;
    tb_stall = 0; acc = '0; fifo_cnt = 0; words_read = 0; force_full = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // End to end: 4 x 20 beats into a depth-16 FIFO drained at random.
    setup(20, 20, 20, 20, 80, 5, 40);
    run_phase("e2e", 4000);
    begin
      int c;
      c = 0;
      while (fifo_cnt > 0 && c < 500) begin
        @(posedge clk); #1;
        drive_cycle();
        c++;
      end
    end
    check("e2e_words_read", 32'(words_read), 32'd80);
    for (int i = 0; i < N; i++) begin
      check("e2e_beats_per_req", 32'(tb_beats[i]), 32'd20);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      check("stats_beat_cnt", 32'(beat_cnt[i*16 +: 16]), 32'd20);
    end
    check("stats_stall_cnt", 32'(stall_cnt), 32'(tb_stall));
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
